// File: rtl/bitwise_and_64.sv
// Bitwise AND slice for the ALU AND/ANDI path: combinational result and zero flag,
// plus a registered copy of both for the ALU output stage.
module bitwise_and_64 #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Y,
   output logic             zero,
   output logic [WIDTH-1:0] Y_q,
   output logic             zero_q
);

   logic [WIDTH-1:0] y_p0;
   logic             zero_p0;
   logic [WIDTH-1:0] y_p1;
   logic             zero_p1;

   // Stage p0: one independent two-input AND cell per bit, no cross-bit paths.
   for (genvar i = 0; i < WIDTH; i++) begin : g_and_cell
      assign y_p0[i] = A[i] & B[i];
   end

   assign zero_p0 = ~|y_p0;
   assign Y       = y_p0;
   assign zero    = zero_p0;

   // Stage p1: output register, loads every cycle; reset wins over data.
   always_ff @(posedge clk) begin
      if (reset) begin
         y_p1    <= '0;
         zero_p1 <= 1'b1;
      end else begin
         y_p1    <= y_p0;
         zero_p1 <= zero_p0;
      end
   end

   assign Y_q    = y_p1;
   assign zero_q = zero_p1;

endmodule

// File: tb/tb_bitwise_and_64.sv
// Bench for bitwise_and_64: directed combinational vectors, reset behaviour and
// randomized register traffic against a behavioural model.
module tb_bitwise_and_64;

   localparam int WIDTH = 64;
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] PAT_A = 64'hAAAA_AAAA_AAAA_AAAA;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic [WIDTH-1:0] Y;
   logic             zero;
   logic [WIDTH-1:0] Y_q;
   logic             zero_q;

   int tests = 0;
   int fails = 0;

   bitwise_and_64 #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .reset  (reset),
      .A      (A),
      .B      (B),
      .Y      (Y),
      .zero   (zero),
      .Y_q    (Y_q),
      .zero_q (zero_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference: bit i of the result is 1 exactly when both operand bits i are 1.
   function automatic logic [WIDTH-1:0] ref_and(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++)
         if (a[i] == 1'b1 && b[i] == 1'b1) r[i] = 1'b1;
      return r;
   endfunction

   task automatic comb_vec(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] e;
      A = a;
      B = b;
      #1;
      e = ref_and(a, b);
      check({tag, "_y"}, Y, e);
      check({tag, "_zero"}, {63'd0, zero}, {63'd0, (e == '0)});
   endtask

   logic [WIDTH-1:0] exp_yq;
   logic             exp_zq;
   logic [WIDTH-1:0] ra, rb;

   initial begin
      // Combinational checks, all within the first few ns and independent of clk.
      comb_vec("ones_aaaa", ONES, PAT_A);
      check("ones_aaaa_const", Y, 64'hAAAA_AAAA_AAAA_AAAA);
      comb_vec("zeros", '0, '0);
      comb_vec("all_ones", ONES, ONES);
      check("all_ones_const", Y, 64'hFFFF_FFFF_FFFF_FFFF);
      comb_vec("lsb_11", 64'd1, 64'd1);
      check("lsb_11_const", Y, 64'd1);
      comb_vec("lsb_10", 64'd1, 64'd0);
      comb_vec("db6d", 64'hDB6D_B6DB_6DB6_DB6D, PAT_A);
      check("db6d_const", Y, 64'h8A28_A28A_28A2_8A28);
      comb_vec("ones_zero", ONES, '0);
      check("ones_zero_const", Y, 64'd0);

      // Reset held for one edge.
      @(negedge clk);
      reset = 1'b1;
      A = ONES;
      B = ONES;
      @(posedge clk);
      #1;
      check("rst_yq", Y_q, '0);
      check("rst_zq", {63'd0, zero_q}, 64'd1);

      // Release reset: first edge captures the current operands.
      @(negedge clk);
      reset = 1'b0;
      A = ONES;
      B = PAT_A;
      @(posedge clk);
      #1;
      check("rel_yq", Y_q, 64'hAAAA_AAAA_AAAA_AAAA);
      check("rel_zq", {63'd0, zero_q}, 64'd0);

      // Mid-stream reset: no effect before the edge, clears on it.
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_before_yq", Y_q, 64'hAAAA_AAAA_AAAA_AAAA);
      check("mid_before_zq", {63'd0, zero_q}, 64'd0);
      @(posedge clk);
      #1;
      check("mid_after_yq", Y_q, '0);
      check("mid_after_zq", {63'd0, zero_q}, 64'd1);

      // Randomized traffic with occasional reset; model tracks the register.
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0: rb = ~ra;
            1: rb = '0;
            2: ra = ONES;
            default: ;
         endcase
         A = ra;
         B = rb;
         reset = ($urandom_range(0, 9) == 0);
         #1;
         check("rnd_y", Y, ref_and(ra, rb));
         check("rnd_zero", {63'd0, zero}, {63'd0, (ref_and(ra, rb) == '0)});
         if (reset) begin
            exp_yq = '0;
            exp_zq = 1'b1;
         end else begin
            exp_yq = ref_and(ra, rb);
            exp_zq = (exp_yq == '0);
         end
         @(posedge clk);
         #1;
         check("rnd_yq", Y_q, exp_yq);
         check("rnd_zq", {63'd0, zero_q}, {63'd0, exp_zq});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
